// File: rtl/pattern_pkg.sv
// Constants shared by the pattern generator and the Moore pattern detector.
package pattern_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int PAT_W_DEF = 5;

  localparam logic [PAT_W_DEF-1:0] DEF_PAT = 5'b11010;

  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] ST_IDLE = 4'b0001;
  localparam logic [ST_W-1:0] ST_SEND = 4'b0010;
  localparam logic [ST_W-1:0] ST_GAP  = 4'b0100;
  localparam logic [ST_W-1:0] ST_FIN  = 4'b1000;

endpackage

// File: rtl/pat_shift_reg.sv
// Parallel-load, left-shift register; with neither load nor shift it holds its contents.
module pat_shift_reg
  import pattern_pkg::*;
#(
  parameter int W = PAT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_val,
  output logic         msb_next
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // MSB as it will stand after this edge, so the caller can register it with valid.
  assign msb_next = sr_d[W-1];

endmodule

// File: rtl/pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first repeat_n times,
// optionally separated by idle gaps, with a freeze (hold) input.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [7:0]       repeat_n,
  input  logic [3:0]       gap,
  input  logic             hold,
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       rep_cnt_q, rep_cnt_d, rep_dec;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [3:0]       gap_rld_q, gap_rld_d;
  logic [PAT_W-1:0] pat_q, pat_d, sr_val;
  logic             active_q, active_d;
  logic             valid_q, valid_d, dout_q, dout_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             sr_load, sr_shift, sr_msb_next;

  pat_shift_reg #(.W(PAT_W)) u_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .shift    (sr_shift),
    .load_val (sr_val),
    .msb_next (sr_msb_next)
  );

  // active_q marks that the current cycle was not a hold cycle, i.e. the bit,
  // gap slot or done pulse on the outputs now really happened and may be retired.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    gap_rld_d = gap_rld_q;
    pat_d     = pat_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_val    = pat_q;
    rep_dec   = (rep_cnt_q != 8'd0) ? rep_cnt_q - 8'd1 : 8'd0;
    active_d  = !hold;

    case (state_q)
      ST_IDLE: begin
        if (start && !hold) begin
          if (repeat_n != 8'd0) begin
            sr_load   = 1'b1;
            sr_val    = pattern;
            pat_d     = pattern;
            rep_cnt_d = repeat_n;
            gap_rld_d = gap;
            bit_cnt_d = '0;
            state_d   = ST_SEND;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_SEND: begin
        if (active_q) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            rep_cnt_d = rep_dec;
            if (rep_dec == 8'd0) begin
              sr_shift = 1'b1;
              state_d  = ST_FIN;
            end else if (gap_rld_q != 4'd0) begin
              sr_shift  = 1'b1;
              gap_cnt_d = gap_rld_q;
              state_d   = ST_GAP;
            end else begin
              sr_load = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sr_shift  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (active_q) begin
          if (gap_cnt_q <= 4'd1) begin
            gap_cnt_d = 4'd0;
            sr_load   = 1'b1;
            state_d   = ST_SEND;
          end else begin
            gap_cnt_d = gap_cnt_q - 4'd1;
          end
        end
      end
      ST_FIN: begin
        if (active_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = !hold && (state_d == ST_SEND);
    dout_d  = valid_d && sr_msb_next;
    done_d  = !hold && (state_d == ST_FIN);
    busy_d  = (state_d == ST_SEND) || (state_d == ST_GAP) || ((state_d == ST_FIN) && hold);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      gap_rld_q <= '0;
      pat_q     <= '0;
      active_q  <= 1'b0;
      valid_q   <= 1'b0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      gap_rld_q <= gap_rld_d;
      pat_q     <= pat_d;
      active_q  <= active_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: per-cycle expected streams from a table plus
// hand-written reset, hold-in-IDLE and 16-bit width sequences.
module tb_pattern_gen;
  import pattern_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, hold, dout, valid, busy, done;
  logic [4:0] pattern;
  logic [7:0] repeat_n;
  logic [3:0] gap;

  logic        start16, dout16, valid16, busy16, done16;
  logic [15:0] pattern16;
  logic [7:0]  repeat16;
  logic [3:0]  gap16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_gen #(.PAT_W(5)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_n(repeat_n),
    .gap(gap), .hold(hold), .dout(dout), .valid(valid), .busy(busy), .done(done)
  );

  pattern_gen #(.PAT_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .pattern(pattern16), .repeat_n(repeat16),
    .gap(gap16), .hold(1'b0), .dout(dout16), .valid(valid16), .busy(busy16), .done(done16)
  );

  // exp holds one char per cycle after the start edge: '1'/'0' bit, '-' idle while busy, 'D' done.
  typedef struct packed {
    logic [4:0]      pat;
    logic [7:0]      rep;
    logic [3:0]      gap;
    logic [31:0]     hold_mask;
    logic [7:0]      len;
    logic [7:0]      det;
    logic [8*24-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " valid"}, valid, 0);
    checkOutput({name, " dout"}, dout, 0);
    checkOutput({name, " busy"}, busy, 0);
    checkOutput({name, " done"}, done, 0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [7:0] c;
    logic [4:0] hist;
    int         det;
    string      tag;
    pattern  = v.pat;
    repeat_n = v.rep;
    gap      = v.gap;
    start    = 1'b1;
    hold     = 1'b0;
    hist     = '0;
    det      = 0;
    for (int k = 1; k <= int'(v.len); k++) begin
      step();
      c   = v.exp[8*(int'(v.len)-k) +: 8];
      tag = $sformatf("v%0d c%0d", idx, k);
      checkOutput({tag, " valid"}, valid, (c == "0" || c == "1"));
      checkOutput({tag, " dout"}, dout, (c == "1"));
      checkOutput({tag, " done"}, done, (c == "D"));
      checkOutput({tag, " busy"}, busy, (c != "D"));
      if (valid) begin
        hist = {hist[3:0], dout};
        if (hist == DEF_PAT) det++;
      end
      // Inputs other than hold are scrambled mid-run; the captured copies must win.
      start     = 1'b1;
      pattern   = ~pattern;
      repeat_n  = 8'($urandom);
      gap       = 4'($urandom);
      hold      = v.hold_mask[k];
    end
    checkOutput($sformatf("v%0d detects", idx), det, v.det);
    step();
    checkIdle($sformatf("v%0d after", idx));
    start = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    int          nbits, berr, ndone, done_at;
    logic [15:0] ref16;

    vecs[0] = '{pat:5'b11010, rep:8'd3, gap:4'd0, hold_mask:32'h0,  len:8'd16, det:8'd3, exp:"110101101011010D"};
    vecs[1] = '{pat:5'b11010, rep:8'd2, gap:4'd3, hold_mask:32'h0,  len:8'd14, det:8'd2, exp:"11010---11010D"};
    vecs[2] = '{pat:5'b10011, rep:8'd1, gap:4'd5, hold_mask:32'h0,  len:8'd6,  det:8'd0, exp:"10011D"};
    vecs[3] = '{pat:5'b01101, rep:8'd0, gap:4'd2, hold_mask:32'h0,  len:8'd1,  det:8'd0, exp:"D"};
    vecs[4] = '{pat:5'b10000, rep:8'd2, gap:4'd1, hold_mask:32'h0,  len:8'd12, det:8'd0, exp:"10000-10000D"};
    vecs[5] = '{pat:5'b10011, rep:8'd1, gap:4'd0, hold_mask:32'hC,  len:8'd8,  det:8'd0, exp:"10--011D"};
    vecs[6] = '{pat:5'b11010, rep:8'd1, gap:4'd0, hold_mask:32'h20, len:8'd7,  det:8'd1, exp:"11010-D"};

    rst = 1'b0; start = 1'b0; hold = 1'b0; pattern = '0; repeat_n = '0; gap = '0;
    start16 = 1'b0; pattern16 = '0; repeat16 = '0; gap16 = '0;
    #1;
    checkIdle("reset");
    step();
    step();
    #2 rst = 1'b1;
    step();
    checkIdle("post reset");

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Hold in IDLE blocks start until released.
    pattern = 5'b11010; repeat_n = 8'd1; gap = 4'd0; start = 1'b1; hold = 1'b1;
    step();
    checkIdle("idle hold 1");
    step();
    checkIdle("idle hold 2");
    hold = 1'b0;
    step();
    checkOutput("idle hold accept valid", valid, 1);
    checkOutput("idle hold accept busy", busy, 1);
    checkOutput("idle hold accept dout", dout, 1);
    start = 1'b0;
    repeat (5) step();
    checkOutput("idle hold done", done, 1);
    step();
    checkIdle("idle hold after");

    // Asynchronous reset mid-stream abandons the run without a done pulse.
    pattern = 5'b11010; repeat_n = 8'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checkOutput("pre reset valid", valid, 1);
    #2 rst = 1'b0;
    #1;
    checkIdle("async reset");
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("reset no done", done, 0);
    end
    #2 rst = 1'b1;
    step();
    checkIdle("reset released");
    applyStimulus(vecs[2], 10);

    // 16-bit instance: 255 repetitions of A5C3, back-to-back.
    ref16 = 16'hA5C3;
    pattern16 = ref16; repeat16 = 8'd255; gap16 = 4'd0; start16 = 1'b1;
    step();
    start16 = 1'b0; pattern16 = 16'h0000; repeat16 = 8'd7;
    nbits = 0; berr = 0; ndone = 0; done_at = 0;
    for (int k = 1; k <= 4090; k++) begin
      if (valid16) begin
        if (dout16 !== ref16[15 - (nbits % 16)]) berr++;
        nbits++;
      end
      if (done16) begin
        ndone++;
        if (done_at == 0) done_at = k;
      end
      step();
    end
    checkOutput("w16 bit count", nbits, 4080);
    checkOutput("w16 bit errors", berr, 0);
    checkOutput("w16 done count", ndone, 1);
    checkOutput("w16 done cycle", done_at, 4081);
    checkOutput("w16 rep_cnt", u_dut16.rep_cnt_q, 0);
    checkOutput("w16 busy after", busy16, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
